// File: rtl/regex_cmd_frontend_pkg.sv
// Shared widths, host command codes and status codes for the regex frontend.
// Imported by the interface, the counter and the frontend top.
package regex_cmd_frontend_pkg;

    localparam int REG_WIDTH      = 32;
    localparam int MEM_ADDR_WIDTH = 12;
    localparam int CC_WIDTH       = 32;

    localparam logic [REG_WIDTH-1:0] CMD_NOP                = 'd0;
    localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 'd1;
    localparam logic [REG_WIDTH-1:0] CMD_READ               = 'd2;
    localparam logic [REG_WIDTH-1:0] CMD_START              = 'd3;
    localparam logic [REG_WIDTH-1:0] CMD_RESET              = 'd4;
    localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 'd5;

    typedef enum logic [1:0] {
        STATUS_IDLE     = 2'd0,
        STATUS_RUNNING  = 2'd1,
        STATUS_ACCEPTED = 2'd2,
        STATUS_REJECTED = 2'd3
    } status_t;

endpackage

// File: rtl/regex_cmd_frontend_if.sv
// Host register / BRAM / core bundle around the regex command frontend.
// slave: the frontend (responder). master: host, memory and core side.
interface regex_cmd_frontend_if;
    import regex_cmd_frontend_pkg::*;

    logic [REG_WIDTH-1:0]      data_in_register;
    logic [REG_WIDTH-1:0]      address_register;
    logic [REG_WIDTH-1:0]      start_cc_pointer_register;
    logic [REG_WIDTH-1:0]      cmd_register;
    logic [REG_WIDTH-1:0]      status_register;
    logic [REG_WIDTH-1:0]      data_o_register;
    logic                      mem_we;
    logic [MEM_ADDR_WIDTH-2:0] mem_waddr;
    logic [31:0]               mem_wdata;
    logic                      mem_re;
    logic [MEM_ADDR_WIDTH-1:0] mem_raddr;
    logic [15:0]               mem_rdata;
    logic                      core_start;
    logic [REG_WIDTH-1:0]      core_cc_pointer;
    logic                      core_abort;
    logic                      core_done;
    logic                      core_accept;

    modport slave (
        input  data_in_register, address_register,
        input  start_cc_pointer_register, cmd_register,
        input  mem_rdata, core_done, core_accept,
        output status_register, data_o_register,
        output mem_we, mem_waddr, mem_wdata,
        output mem_re, mem_raddr,
        output core_start, core_cc_pointer, core_abort
    );

    modport master (
        output data_in_register, address_register,
        output start_cc_pointer_register, cmd_register,
        output mem_rdata, core_done, core_accept,
        input  status_register, data_o_register,
        input  mem_we, mem_waddr, mem_wdata,
        input  mem_re, mem_raddr,
        input  core_start, core_cc_pointer, core_abort
    );

endinterface

// File: rtl/regex_cmd_frontend_counter.sv
// Saturating elapsed-clock counter with synchronous clear and enable.
// Ports: clk, reset, i_clr, i_en in; o_count out (CC_WIDTH).
module cmd_elapsed_counter
    import regex_cmd_frontend_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clr,
    input  logic                i_en,
    output logic [CC_WIDTH-1:0] o_count
);

    logic [CC_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/regex_cmd_frontend.sv
// Host command decoder for the regex coprocessor: BRAM writes/reads,
// core start/abort, status and elapsed clocks. Ports: clk, reset, bus.
module regex_cmd_frontend
    import regex_cmd_frontend_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    regex_cmd_frontend_if.slave  bus
);

    status_t r_status;
    status_t w_status_next;

    logic w_cmd_write;
    logic w_cmd_read;
    logic w_cmd_start;
    logic w_cmd_reset;
    logic w_cmd_elapsed;
    logic w_running;
    logic w_start;
    logic w_abort;
    logic w_clr;
    logic w_en;
    logic w_wr_ok;
    logic w_rd_ok;

    logic [CC_WIDTH-1:0]       w_count;
    logic [REG_WIDTH-1:0]      r_data_o;
    logic                      r_rd_pend;
    logic                      r_mem_we;
    logic [MEM_ADDR_WIDTH-2:0] r_mem_waddr;
    logic [31:0]               r_mem_wdata;
    logic                      r_mem_re;
    logic [MEM_ADDR_WIDTH-1:0] r_mem_raddr;
    logic                      r_core_start;
    logic                      r_core_abort;
    logic [REG_WIDTH-1:0]      r_cc_ptr;

    // Upper address bits have no meaning for the BRAM.
    logic w_unused_addr;
    assign w_unused_addr =
        ^bus.address_register[REG_WIDTH-1:MEM_ADDR_WIDTH];

    always_comb begin
        w_cmd_write   = 1'b0;
        w_cmd_read    = 1'b0;
        w_cmd_start   = 1'b0;
        w_cmd_reset   = 1'b0;
        w_cmd_elapsed = 1'b0;
        case (bus.cmd_register)
            CMD_WRITE:              w_cmd_write   = 1'b1;
            CMD_READ:               w_cmd_read    = 1'b1;
            CMD_START:              w_cmd_start   = 1'b1;
            CMD_RESET:              w_cmd_reset   = 1'b1;
            CMD_READ_ELAPSED_CLOCK: w_cmd_elapsed = 1'b1;
            default: ;
        endcase
    end

    assign w_running = (r_status == STATUS_RUNNING);
    assign w_wr_ok   = w_cmd_write && !w_running;
    assign w_rd_ok   = w_cmd_read && !w_running;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_status <= STATUS_IDLE;
        end else begin
            r_status <= w_status_next;
        end
    end

    // CMD_RESET takes priority over a coincident core_done.
    always_comb begin
        w_status_next = r_status;
        w_start       = 1'b0;
        w_abort       = 1'b0;
        w_clr         = 1'b0;
        w_en          = 1'b0;
        if (w_cmd_reset) begin
            w_status_next = STATUS_IDLE;
            w_clr         = 1'b1;
            w_abort       = w_running;
        end else begin
            case (r_status)
                STATUS_RUNNING: begin
                    if (bus.core_done) begin
                        w_status_next = bus.core_accept ?
                            STATUS_ACCEPTED : STATUS_REJECTED;
                    end else begin
                        w_en = 1'b1;
                    end
                end
                default: begin
                    if (w_cmd_start) begin
                        w_status_next = STATUS_RUNNING;
                        w_start       = 1'b1;
                        w_clr         = 1'b1;
                    end
                end
            endcase
        end
    end

    cmd_elapsed_counter u_counter (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_o     <= '0;
            r_rd_pend    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_waddr  <= '0;
            r_mem_wdata  <= '0;
            r_mem_re     <= 1'b0;
            r_mem_raddr  <= '0;
            r_core_start <= 1'b0;
            r_core_abort <= 1'b0;
            r_cc_ptr     <= '0;
        end else begin
            r_mem_we <= w_wr_ok;
            if (w_wr_ok) begin
                r_mem_waddr <=
                    bus.address_register[MEM_ADDR_WIDTH-1:1];
                r_mem_wdata <= bus.data_in_register[31:0];
            end
            r_mem_re <= w_rd_ok;
            if (w_rd_ok) begin
                r_mem_raddr <=
                    bus.address_register[MEM_ADDR_WIDTH-1:0];
            end
            r_rd_pend <= r_mem_re;
            if (r_rd_pend) begin
                r_data_o <= REG_WIDTH'(bus.mem_rdata);
            end
            if (w_cmd_elapsed) begin
                r_data_o <= REG_WIDTH'(w_count);
            end
            r_core_start <= w_start;
            r_core_abort <= w_abort;
            if (w_start) begin
                r_cc_ptr <= bus.start_cc_pointer_register;
            end
        end
    end

    // BRAM data is forwarded in the cycle it arrives, then held.
    assign bus.data_o_register = r_rd_pend ?
        REG_WIDTH'(bus.mem_rdata) : r_data_o;
    assign bus.status_register = REG_WIDTH'(r_status);
    assign bus.mem_we          = r_mem_we;
    assign bus.mem_waddr       = r_mem_waddr;
    assign bus.mem_wdata       = r_mem_wdata;
    assign bus.mem_re          = r_mem_re;
    assign bus.mem_raddr       = r_mem_raddr;
    assign bus.core_start      = r_core_start;
    assign bus.core_abort      = r_core_abort;
    assign bus.core_cc_pointer = r_cc_ptr;

endmodule

// File: tb/tb_regex_cmd_frontend.sv
// Directed bench for regex_cmd_frontend with a BRAM model.
// Drives at posedge+1, checks at posedge+1.
module tb_regex_cmd_frontend;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   n_we;
    int   n_re;
    int   n_start;
    int   n_abort;

    logic [31:0] mem [0:2047];

    regex_cmd_frontend_if bus ();

    regex_cmd_frontend dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
        if (bus.mem_re) begin
            if (bus.mem_raddr[0])
                bus.mem_rdata <= mem[bus.mem_raddr[11:1]][31:16];
            else
                bus.mem_rdata <= mem[bus.mem_raddr[11:1]][15:0];
        end
    end

    always @(negedge clk) begin
        if (bus.mem_we)     n_we++;
        if (bus.mem_re)     n_re++;
        if (bus.core_start) n_start++;
        if (bus.core_abort) n_abort++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_status"}, bus.status_register, 32'd0);
        chk({tag, "_data_o"}, bus.data_o_register, 32'd0);
        chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_re"}, 32'(bus.mem_re), 32'd0);
        chk({tag, "_start"}, 32'(bus.core_start), 32'd0);
        chk({tag, "_abort"}, 32'(bus.core_abort), 32'd0);
        chk({tag, "_ccptr"}, bus.core_cc_pointer, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n_we = 0; n_re = 0; n_start = 0; n_abort = 0;
        reset = 1'b1;
        bus.data_in_register          = '0;
        bus.address_register          = '0;
        bus.start_cc_pointer_register = '0;
        bus.cmd_register              = 32'd0;
        bus.core_done                 = 1'b0;
        bus.core_accept               = 1'b0;
        bus.mem_rdata                 = '0;
        tick();
        tick();
        chk_reset_vals("rst");
        reset = 1'b0;
        tick();

        // single write
        n_we = 0;
        bus.address_register = 32'd4;
        bus.data_in_register = 32'h0302_0100;
        bus.cmd_register     = 32'd1;
        tick();
        chk("wr_we", 32'(bus.mem_we), 32'd1);
        chk("wr_waddr", 32'(bus.mem_waddr), 32'd2);
        chk("wr_wdata", bus.mem_wdata, 32'h0302_0100);
        bus.cmd_register = 32'd0;
        tick();
        chk("wr_we_off", 32'(bus.mem_we), 32'd0);
        tick();
        chk("wr_count", 32'(n_we), 32'd1);

        // streamed read of halfwords 4, 5
        bus.address_register = 32'd4;
        bus.cmd_register     = 32'd2;
        tick();
        chk("rd_re", 32'(bus.mem_re), 32'd1);
        chk("rd_raddr", 32'(bus.mem_raddr), 32'd4);
        bus.address_register = 32'd5;
        tick();
        chk("rd_data4", bus.data_o_register, 32'h0000_0100);
        chk("rd_raddr5", 32'(bus.mem_raddr), 32'd5);
        bus.cmd_register = 32'd0;
        tick();
        chk("rd_data5", bus.data_o_register, 32'h0000_0302);
        tick();
        chk("rd_hold", bus.data_o_register, 32'h0000_0302);

        // accepted run, done after 25 counted cycles
        n_start = 0;
        bus.start_cc_pointer_register = 32'h40;
        bus.cmd_register = 32'd3;
        tick();
        chk("st_pulse", 32'(bus.core_start), 32'd1);
        chk("st_ptr", bus.core_cc_pointer, 32'h40);
        chk("st_run", bus.status_register, 32'd1);
        tick();
        chk("st_pulse_off", 32'(bus.core_start), 32'd0);
        bus.cmd_register = 32'd0;
        repeat (24) tick();
        chk("st_still_run", bus.status_register, 32'd1);
        bus.core_done   = 1'b1;
        bus.core_accept = 1'b1;
        tick();
        bus.core_done   = 1'b0;
        bus.core_accept = 1'b0;
        chk("acc_status", bus.status_register, 32'd2);
        chk("acc_starts", 32'(n_start), 32'd1);
        bus.cmd_register = 32'd5;
        tick();
        bus.cmd_register = 32'd0;
        chk("acc_elapsed", bus.data_o_register, 32'd25);

        // reject run with lockout of write/read
        bus.cmd_register = 32'd3;
        tick();
        chk("rj_run", bus.status_register, 32'd1);
        n_we = 0;
        n_re = 0;
        bus.address_register = 32'd8;
        bus.data_in_register = 32'hDEAD_BEEF;
        bus.cmd_register     = 32'd1;
        tick();
        bus.cmd_register = 32'd2;
        tick();
        bus.cmd_register = 32'd0;
        tick();
        tick();
        chk("lk_we", 32'(n_we), 32'd0);
        chk("lk_re", 32'(n_re), 32'd0);
        chk("lk_data", bus.data_o_register, 32'd25);
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        chk("rj_status", bus.status_register, 32'd3);

        // abort: CMD_RESET coincident with core_done
        n_abort = 0;
        bus.cmd_register = 32'd3;
        tick();
        chk("ab_run", bus.status_register, 32'd1);
        bus.cmd_register = 32'd0;
        repeat (3) tick();
        bus.cmd_register = 32'd4;
        bus.core_done    = 1'b1;
        bus.core_accept  = 1'b1;
        tick();
        bus.core_done    = 1'b0;
        bus.core_accept  = 1'b0;
        chk("ab_pulse", 32'(bus.core_abort), 32'd1);
        chk("ab_status", bus.status_register, 32'd0);
        bus.cmd_register = 32'd5;
        tick();
        bus.cmd_register = 32'd0;
        chk("ab_count", bus.data_o_register, 32'd0);
        chk("ab_pulses", 32'(n_abort), 32'd1);

        // synchronous reset in the middle of a write burst
        bus.address_register = 32'd4;
        bus.cmd_register     = 32'd2;
        tick();
        bus.address_register = 32'd10;
        bus.data_in_register = 32'hAABB_CCDD;
        bus.cmd_register     = 32'd1;
        tick();
        chk("br_we", 32'(bus.mem_we), 32'd1);
        chk("br_data", bus.data_o_register, 32'h0000_0100);
        bus.address_register = 32'd11;
        tick();
        chk("br_ptr", bus.core_cc_pointer, 32'h40);
        reset = 1'b1;
        tick();
        chk_reset_vals("mid");
        reset = 1'b0;
        bus.cmd_register = 32'd0;
        tick();
        chk("post_we", 32'(bus.mem_we), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
